// File: rtl/sim_uart_in_responder_pkg.sv
// Shared UART simulation types and constants for the UART input responder
// and the UART output printer.
package sim_uart_pkg;

    typedef logic [7:0] uart_ch_t;

    localparam uart_ch_t UART_IDLE_CH = 8'hff;

endpackage

// File: rtl/sim_uart_in_responder_if.sv
// Host push channel and DUT getc channel of the UART input responder.
interface sim_uart_in_responder_if;
    import sim_uart_pkg::*;

    logic     push_valid;
    uart_ch_t push_ch;
    logic     push_ready;
    logic     io_uart_in_valid;
    uart_ch_t io_uart_in_ch;

    modport master (
        output push_valid,
        output push_ch,
        output io_uart_in_valid,
        input  push_ready,
        input  io_uart_in_ch
    );

    modport slave (
        input  push_valid,
        input  push_ch,
        input  io_uart_in_valid,
        output push_ready,
        output io_uart_in_ch
    );
endinterface

// File: rtl/sim_uart_in_responder_fifo.sv
// Synchronous character FIFO; the caller guarantees no push when full and
// no pop when empty. Level is a separate counter so full/empty are unambiguous.
module sim_uart_fifo
    import sim_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  uart_ch_t               din,
    output uart_ch_t               dout,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    uart_ch_t        mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [AW:0]     level_q, level_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[tail_q] <= din;
    end

    assign dout  = mem_q[head_q];
    assign level = level_q;
endmodule

// File: rtl/sim_uart_in_responder.sv
// UART input responder: buffers host characters and answers DUT getc requests,
// returning the idle code when nothing is deliverable. SIM_UART_IN_ECHO_EN echoes pops.
module sim_uart_in_responder
    import sim_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned GAP   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    sim_uart_in_responder_if.slave   bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              delivered_cnt
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   dcnt_q, dcnt_d;
    uart_ch_t      head_ch;
    logic          avail;
    logic          push;
    logic          pop;

    sim_uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.push_ch),
        .dout  (head_ch),
        .level (level)
    );

    // Readiness looks only at registered level, so a same-cycle pop never frees a slot.
    assign bus.push_ready   = (level != LW'(DEPTH));
    assign avail            = (level != '0) && (gap_q == '0);
    assign push             = bus.push_valid && bus.push_ready && !reset;
    assign pop              = bus.io_uart_in_valid && avail && !reset;
    assign bus.io_uart_in_ch = avail ? head_ch : UART_IDLE_CH;

    always_comb begin
        gap_d  = gap_q;
        dcnt_d = dcnt_q;
        if (pop) begin
            gap_d  = GW'(GAP);
            dcnt_d = dcnt_q + 32'd1;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gap_q  <= '0;
            dcnt_q <= '0;
        end else begin
            gap_q  <= gap_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign delivered_cnt = dcnt_q;

`ifdef SIM_UART_IN_ECHO_EN
    always_ff @(posedge clock) begin
        if (pop) begin
            $write("%c", head_ch);
        end
    end
`else
`endif
endmodule

// File: tb/tb_sim_uart_in_responder.sv
// Directed bench: three responder instances (default, GAP=3, DEPTH=4) on one clock.
module tb_sim_uart_in_responder;
    import sim_uart_pkg::*;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    sim_uart_in_responder_if b0 ();
    sim_uart_in_responder_if b1 ();
    sim_uart_in_responder_if b2 ();

    logic [4:0]  level0, level1;
    logic [2:0]  level2;
    logic [31:0] dcnt0, dcnt1, dcnt2;

    sim_uart_in_responder #(.DEPTH(16), .GAP(0)) dut0 (
        .clock(clk), .reset(rst), .bus(b0.slave), .level(level0), .delivered_cnt(dcnt0));
    sim_uart_in_responder #(.DEPTH(16), .GAP(3)) dut1 (
        .clock(clk), .reset(rst), .bus(b1.slave), .level(level1), .delivered_cnt(dcnt1));
    sim_uart_in_responder #(.DEPTH(4), .GAP(0)) dut2 (
        .clock(clk), .reset(rst), .bus(b2.slave), .level(level2), .delivered_cnt(dcnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (level0 !== 5'd0) $display("FAIL reset_level got=%0d exp=0", level0); else passed++;
        total++; if (b0.push_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", b0.push_ready); else passed++;
        total++; if (b0.io_uart_in_ch !== 8'hff) $display("FAIL reset_ch got=%h exp=ff", b0.io_uart_in_ch); else passed++;
        total++; if (dcnt0 !== 32'd0) $display("FAIL reset_dcnt got=%0d exp=0", dcnt0); else passed++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b0.io_uart_in_valid = 1'b1;
            total++; if (b0.io_uart_in_ch !== 8'hff) $display("FAIL idle_ch[%0d] got=%h exp=ff", i, b0.io_uart_in_ch); else passed++;
        end
        @(negedge clk);
        b0.io_uart_in_valid = 1'b0;
        total++; if (dcnt0 !== 32'd0) $display("FAIL idle_dcnt got=%0d exp=0", dcnt0); else passed++;
        total++; if (level0 !== 5'd0) $display("FAIL idle_level got=%0d exp=0", level0); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h41, 8'h42, 8'h43, 8'hff};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b0.push_valid = 1'b1;
            b0.push_ch    = 8'h41 + 8'(i);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b0.push_valid       = 1'b0;
            b0.io_uart_in_valid = 1'b1;
            if (i == 0) begin
                total++; if (level0 !== 5'd3) $display("FAIL b2b_level got=%0d exp=3", level0); else passed++;
            end
            total++; if (b0.io_uart_in_ch !== exp[i]) $display("FAIL b2b_ch[%0d] got=%h exp=%h", i, b0.io_uart_in_ch, exp[i]); else passed++;
        end
        @(negedge clk);
        b0.io_uart_in_valid = 1'b0;
        total++; if (dcnt0 !== 32'd3) $display("FAIL b2b_dcnt got=%0d exp=3", dcnt0); else passed++;
        total++; if (level0 !== 5'd0) $display("FAIL b2b_level_end got=%0d exp=0", level0); else passed++;
    endtask

    task automatic test_push_request_same_cycle();
        @(negedge clk);
        b0.push_valid       = 1'b1;
        b0.push_ch          = 8'h55;
        b0.io_uart_in_valid = 1'b1;
        total++; if (b0.io_uart_in_ch !== 8'hff) $display("FAIL nobypass_ch got=%h exp=ff", b0.io_uart_in_ch); else passed++;
        @(negedge clk);
        b0.push_valid = 1'b0;
        total++; if (b0.io_uart_in_ch !== 8'h55) $display("FAIL nobypass_next got=%h exp=55", b0.io_uart_in_ch); else passed++;
        @(negedge clk);
        b0.io_uart_in_valid = 1'b0;
        total++; if (dcnt0 !== 32'd4) $display("FAIL nobypass_dcnt got=%0d exp=4", dcnt0); else passed++;
        total++; if (b0.io_uart_in_ch !== 8'hff) $display("FAIL nobypass_empty got=%h exp=ff", b0.io_uart_in_ch); else passed++;
    endtask

    task automatic test_gap();
        logic [7:0] exp [5];
        exp = '{8'h61, 8'hff, 8'hff, 8'hff, 8'h62};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            b1.push_valid = 1'b1;
            b1.push_ch    = 8'h61 + 8'(i);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b1.push_valid       = 1'b0;
            b1.io_uart_in_valid = 1'b1;
            total++; if (b1.io_uart_in_ch !== exp[i]) $display("FAIL gap_ch[%0d] got=%h exp=%h", i, b1.io_uart_in_ch, exp[i]); else passed++;
        end
        @(negedge clk);
        b1.io_uart_in_valid = 1'b0;
        total++; if (dcnt1 !== 32'd2) $display("FAIL gap_dcnt got=%0d exp=2", dcnt1); else passed++;
        total++; if (level1 !== 5'd0) $display("FAIL gap_level got=%0d exp=0", level1); else passed++;
    endtask

    task automatic test_full_wrap();
        logic [7:0] exp [5];
        exp = '{8'h11, 8'h12, 8'h13, 8'h20, 8'hff};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (b2.push_ready !== (i < 4)) $display("FAIL full_ready[%0d] got=%b exp=%b", i, b2.push_ready, (i < 4)); else passed++;
            b2.push_valid = 1'b1;
            b2.push_ch    = 8'h10 + 8'(i);
        end
        @(negedge clk);
        b2.push_valid = 1'b0;
        total++; if (level2 !== 3'd4) $display("FAIL full_level got=%0d exp=4", level2); else passed++;
        total++; if (b2.push_ready !== 1'b0) $display("FAIL full_ready_hold got=%b exp=0", b2.push_ready); else passed++;
        b2.io_uart_in_valid = 1'b1;
        total++; if (b2.io_uart_in_ch !== 8'h10) $display("FAIL full_first got=%h exp=10", b2.io_uart_in_ch); else passed++;
        @(negedge clk);
        b2.io_uart_in_valid = 1'b0;
        total++; if (b2.push_ready !== 1'b1) $display("FAIL full_ready_after_pop got=%b exp=1", b2.push_ready); else passed++;
        total++; if (level2 !== 3'd3) $display("FAIL full_level_after_pop got=%0d exp=3", level2); else passed++;
        b2.push_valid = 1'b1;
        b2.push_ch    = 8'h20;
        @(negedge clk);
        b2.push_valid = 1'b0;
        total++; if (level2 !== 3'd4) $display("FAIL wrap_level got=%0d exp=4", level2); else passed++;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            b2.io_uart_in_valid = 1'b1;
            total++; if (b2.io_uart_in_ch !== exp[i]) $display("FAIL wrap_ch[%0d] got=%h exp=%h", i, b2.io_uart_in_ch, exp[i]); else passed++;
        end
        @(negedge clk);
        b2.io_uart_in_valid = 1'b0;
        total++; if (dcnt2 !== 32'd5) $display("FAIL wrap_dcnt got=%0d exp=5", dcnt2); else passed++;
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b0.push_valid = 1'b1;
            b0.push_ch    = 8'h71 + 8'(i);
        end
        @(negedge clk);
        b0.push_valid = 1'b0;
        total++; if (level0 !== 5'd3) $display("FAIL flush_pre_level got=%0d exp=3", level0); else passed++;
        rst                 = 1'b1;
        b0.io_uart_in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (level0 !== 5'd0) $display("FAIL flush_level got=%0d exp=0", level0); else passed++;
        total++; if (dcnt0 !== 32'd0) $display("FAIL flush_dcnt got=%0d exp=0", dcnt0); else passed++;
        total++; if (b0.push_ready !== 1'b1) $display("FAIL flush_ready got=%b exp=1", b0.push_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (b0.io_uart_in_ch !== 8'hff) $display("FAIL flush_ch[%0d] got=%h exp=ff", i, b0.io_uart_in_ch); else passed++;
        end
        @(negedge clk);
        b0.io_uart_in_valid = 1'b0;
        total++; if (dcnt0 !== 32'd0) $display("FAIL flush_dcnt_end got=%0d exp=0", dcnt0); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        b0.push_valid = 1'b0; b0.push_ch = '0; b0.io_uart_in_valid = 1'b0;
        b1.push_valid = 1'b0; b1.push_ch = '0; b1.io_uart_in_valid = 1'b0;
        b2.push_valid = 1'b0; b2.push_ch = '0; b2.io_uart_in_valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_push_request_same_cycle();
        test_gap();
        test_full_wrap();
        test_reset_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
